// File: rtl/fifo_drain.sv
// fifo_drain: drains an 8-bit FIFO into little-endian 32-bit words on a valid/ready master port.
// Define FIFO_DRAIN_TIMEOUT_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_drain #(
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             WEN,
  output logic             REN,
  input  logic [7:0]       RDATA,
  output logic [31:0]      M_DATA,
  output logic [3:0]       M_BE,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [CNT_W-1:0] LEVEL,
  output logic             OVF
);
  typedef enum logic {FILL, OUT} state_t;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_level;
  logic             r_ovf;
  logic [2:0]       r_issued;
  logic             r_inflight;
  logic [1:0]       r_lane;
  logic [31:0]      r_buf, w_buf;
  logic [3:0]       r_cap, w_cap;
  logic [31:0]      r_mdata;
  logic [3:0]       r_mbe;
  logic             r_mvalid;
  logic             w_ren, w_load, w_hs, w_full, w_timeout;
  assign w_full = r_level == CNT_W'(DEPTH);
  assign w_hs   = r_state == OUT && M_READY;
`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] r_idle;
  logic          w_idle;
  // Idle only when a partial word is parked and nothing more can arrive.
  assign w_idle    = r_state == FILL && r_issued != 3'd0 && !r_inflight && r_level == '0;
  assign w_timeout = w_idle && r_idle == IW'(TIMEOUT - 1);
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) r_idle <= '0;
    else if (w_ren || w_hs || w_timeout) r_idle <= '0;
    else if (w_idle) r_idle <= r_idle + IW'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif
  // Merge the byte landing this cycle so a completed word can be loaded on the same edge.
  always_comb begin
    w_buf = r_buf;
    w_cap = r_cap;
    if (r_inflight) begin
      w_buf[8*r_lane +: 8] = RDATA;
      w_cap[r_lane]        = 1'b1;
    end
  end
  always_comb begin
    w_ren  = 1'b0;
    w_load = 1'b0;
    w_next = r_state;
    if (r_state == FILL) begin
      w_ren  = r_level != '0 && r_issued < 3'd4;
      w_load = (r_inflight && r_lane == 2'd3) || w_timeout;
      w_next = w_load ? OUT : FILL;
    end else begin
      w_next = M_READY ? FILL : OUT;
    end
  end
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) r_state <= FILL;
    else r_state <= w_next;
  end
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_lane     <= '0;
      r_buf      <= '0;
      r_cap      <= '0;
      r_mdata    <= '0;
      r_mbe      <= '0;
      r_mvalid   <= 1'b0;
    end else begin
      r_level    <= (WEN && !w_ren && !w_full) ? r_level + CNT_W'(1) :
                    (w_ren && !WEN)            ? r_level - CNT_W'(1) : r_level;
      r_ovf      <= r_ovf | (WEN && !w_ren && w_full);
      r_inflight <= w_ren;
      r_lane     <= r_issued[1:0];
      r_issued   <= w_hs ? 3'd0 : r_issued + {2'b00, w_ren};
      r_buf      <= w_hs ? 32'd0 : w_buf;
      r_cap      <= w_hs ? 4'd0 : w_cap;
      if (w_load) begin
        r_mdata  <= w_buf;
        r_mbe    <= w_cap;
        r_mvalid <= 1'b1;
      end else if (w_hs) begin
        r_mvalid <= 1'b0;
      end
    end
  end
  assign REN     = w_ren;
  assign M_DATA  = r_mdata;
  assign M_BE    = r_mbe;
  assign M_VALID = r_mvalid;
  assign LEVEL   = r_level;
  assign OVF     = r_ovf;
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed table plus corner sequences for fifo_drain, with a byte-queue FIFO model.
module tb_fifo_drain;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        WEN = 1'b0;
  logic        REN;
  logic [7:0]  RDATA = 8'h00;
  logic [31:0] M_DATA;
  logic [3:0]  M_BE;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [4:0]  LEVEL;
  logic        OVF;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  q[$];
  bit          pend;
  int          checks = 0;
  int          fails = 0;

  fifo_drain #(.DEPTH(16), .CNT_W(5), .TIMEOUT(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .WEN(WEN), .REN(REN), .RDATA(RDATA),
    .M_DATA(M_DATA), .M_BE(M_BE), .M_VALID(M_VALID), .M_READY(M_READY),
    .LEVEL(LEVEL), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // FIFO model: RDATA for a REN in cycle t is presented from mid t+1, ahead of the capture edge.
  always @(negedge CLK) begin
    if (RSTn) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (pend && q.size() > 0) RDATA = q.pop_front();
      pend = REN;
      if (WEN && q.size() < 16) q.push_back(wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  typedef struct {
    bit          wen;
    logic [7:0]  wd;
    bit          rdy;
    bit          ren;
    logic [4:0]  lvl;
    bit          vld;
    logic [31:0] data;
    logic [3:0]  be;
  } vec_t;
  vec_t vec[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit wen, input logic [7:0] wd, input bit rdy);
    @(posedge CLK);
    #1;
    WEN = wen;
    wdata = wd;
    M_READY = rdy;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    WEN = 1'b0;
    M_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b0;
  endtask

  task automatic get_word(input string nm, input logic [31:0] exp_d, input logic [3:0] exp_be);
    bit got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      step(1'b0, 8'h00, 1'b1);
      if (M_VALID) begin
        got = 1;
        chk({nm, "_data"}, M_DATA, exp_d);
        chk({nm, "_be"}, {28'd0, M_BE}, {28'd0, exp_be});
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s: got no M_VALID in 60 cycles, required a word", nm);
    end
  endtask

  initial begin
    logic [31:0] words[5];
    bit seen;
    vec[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 4'h0};
    vec[1]  = '{1'b1, 8'h01, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0, 4'h0};
    vec[2]  = '{1'b1, 8'h02, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0, 4'h0};
    vec[3]  = '{1'b1, 8'h03, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0, 4'h0};
    vec[4]  = '{1'b1, 8'h04, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0, 4'h0};
    vec[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 5'd1, 1'b0, 32'h0, 4'h0};
    vec[6]  = '{1'b1, 8'h06, 1'b1, 1'b0, 5'd2, 1'b1, 32'h03020100, 4'hF};
    vec[7]  = '{1'b1, 8'h07, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0, 4'h0};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0, 4'h0};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd2, 1'b0, 32'h0, 4'h0};
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0, 4'h0};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 4'h0};
    vec[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 32'h07060504, 4'hF};
    vec[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 4'h0};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ren", {31'd0, REN}, 32'd0);
    chk("rst_data", M_DATA, 32'd0);
    chk("rst_be", {28'd0, M_BE}, 32'd0);
    chk("rst_valid", {31'd0, M_VALID}, 32'd0);
    chk("rst_level", {27'd0, LEVEL}, 32'd0);
    chk("rst_ovf", {31'd0, OVF}, 32'd0);
    @(posedge CLK);
    #1;
    RSTn = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(vec[i].wen, vec[i].wd, vec[i].rdy);
      chk($sformatf("vec%0d_ren", i), {31'd0, REN}, {31'd0, vec[i].ren});
      chk($sformatf("vec%0d_level", i), {27'd0, LEVEL}, {27'd0, vec[i].lvl});
      chk($sformatf("vec%0d_valid", i), {31'd0, M_VALID}, {31'd0, vec[i].vld});
      if (vec[i].vld) begin
        chk($sformatf("vec%0d_data", i), M_DATA, vec[i].data);
        chk($sformatf("vec%0d_be", i), {28'd0, M_BE}, {28'd0, vec[i].be});
      end
    end

    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b0, 8'h00, 1'b0);
      seen = M_VALID;
    end
    chk("bp_first_valid", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(i < 17, 8'(8'h20 + i), 1'b0);
      chk($sformatf("bp%0d_ren", i), {31'd0, REN}, 32'd0);
      chk($sformatf("bp%0d_valid", i), {31'd0, M_VALID}, 32'd1);
      chk($sformatf("bp%0d_data", i), M_DATA, 32'h13121110);
      chk($sformatf("bp%0d_level", i), {27'd0, LEVEL}, (i < 16) ? i : 16);
      chk($sformatf("bp%0d_ovf", i), {31'd0, OVF}, {31'd0, i >= 17});
    end
    words = '{32'h13121110, 32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C};
    for (int w = 0; w < 5; w++) get_word($sformatf("drain%0d", w), words[w], 4'hF);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    chk("drain_level", {27'd0, LEVEL}, 32'd0);
    chk("drain_ovf", {31'd0, OVF}, 32'd1);

    step(1'b1, 8'h51, 1'b1);
    step(1'b1, 8'h52, 1'b1);
    step(1'b1, 8'h53, 1'b1);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    WEN = 1'b0;
    @(negedge CLK);
    chk("mid_rst_ren", {31'd0, REN}, 32'd0);
    chk("mid_rst_data", M_DATA, 32'd0);
    chk("mid_rst_be", {28'd0, M_BE}, 32'd0);
    chk("mid_rst_valid", {31'd0, M_VALID}, 32'd0);
    chk("mid_rst_level", {27'd0, LEVEL}, 32'd0);
    chk("mid_rst_ovf", {31'd0, OVF}, 32'd0);
    @(posedge CLK);
    #1;
    RSTn = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b1);
    get_word("post_rst", 32'h64636261, 4'hF);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 8'h00, 1'b1);
      seen |= M_VALID;
    end
    chk("post_rst_extra_valid", {31'd0, seen}, 32'd0);
    chk("post_rst_level", {27'd0, LEVEL}, 32'd0);

    do_reset();
    step(1'b1, 8'hA1, 1'b1);
    step(1'b1, 8'hB2, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
`ifdef FIFO_DRAIN_TIMEOUT_EN
    seen = 0;
    for (int k = 0; k < 34; k++) begin
      step(1'b0, 8'h00, 1'b1);
      seen |= M_VALID;
    end
    chk("to_early_valid", {31'd0, seen}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("to_valid", {31'd0, M_VALID}, 32'd1);
    chk("to_data", M_DATA, 32'h00C3B2A1);
    chk("to_be", {28'd0, M_BE}, 32'h7);
`else
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 8'h00, 1'b1);
      seen |= M_VALID;
    end
    chk("no_to_valid", {31'd0, seen}, 32'd0);
    chk("no_to_ren", {31'd0, REN}, 32'd0);
    chk("no_to_level", {27'd0, LEVEL}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
